// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - in-order issue/commit scoreboard with out-of-order writeback
package scoreboard_pkg;
  localparam int NR_SB_ENTRIES = 4;
  localparam int NR_WB_PORTS   = 4;
  localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [7:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    logic                     use_imm;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NR_ENTRIES = NR_SB_ENTRIES,
  parameter int NR_WB      = NR_WB_PORTS,
  localparam int TW        = $clog2(NR_ENTRIES),
  localparam int WW        = (NR_WB > 1) ? $clog2(NR_WB) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  output logic                          full_o,
  input  scoreboard_entry_t             decoded_instr_i,
  input  logic                          decoded_valid_i,
  output logic                          decoded_ack_o,
  output logic [TW-1:0]                 issued_trans_id_o,
  output logic [31:0]                   rd_clobber_o,
  input  logic [NR_WB-1:0][TW-1:0]      wb_trans_id_i,
  input  logic [NR_WB-1:0][63:0]        wb_data_i,
  input  exception_t [NR_WB-1:0]        wb_ex_i,
  input  logic [NR_WB-1:0]              wb_valid_i,
  output scoreboard_entry_t             commit_instr_o,
  output logic                          commit_valid_o,
  input  logic                          commit_ack_i
);

  scoreboard_entry_t mem [NR_ENTRIES];
  logic [TW-1:0]     issue_ptr, commit_ptr;
  logic [TW:0]       count;

  logic [NR_ENTRIES-1:0] in_flight;
  logic [NR_ENTRIES-1:0] wb_hit;
  logic [WW-1:0]         wb_sel [NR_ENTRIES];
  logic                  issue_fire, commit_fire;
  scoreboard_entry_t     issue_entry;

  assign full_o            = (count == (TW+1)'(NR_ENTRIES));
  assign decoded_ack_o     = decoded_valid_i & ~full_o & ~flush_i;
  assign issued_trans_id_o = issue_ptr;
  assign commit_instr_o    = mem[commit_ptr];
  assign commit_valid_o    = (count != '0) & mem[commit_ptr].valid;
  assign issue_fire        = decoded_ack_o;
  assign commit_fire       = commit_ack_i & commit_valid_o;

  // An entry is in flight when its distance from the commit pointer is below count.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < NR_ENTRIES; i++)
      in_flight[i] = ({1'b0, TW'(TW'(i) - commit_ptr)} < count);
  end

  // Scan ports high to low so the lowest-numbered port is the final selection.
  always_comb begin
    wb_hit = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      wb_sel[i] = '0;
      for (int p = NR_WB-1; p >= 0; p--) begin
        if (wb_valid_i[p] && (wb_trans_id_i[p] == TW'(i))) begin
          wb_hit[i] = 1'b1;
          wb_sel[i] = WW'(p);
        end
      end
      if (!in_flight[i] || (commit_fire && (TW'(i) == commit_ptr)))
        wb_hit[i] = 1'b0;
    end
  end

  always_comb begin
    issue_entry          = decoded_instr_i;
    issue_entry.trans_id = TRANS_ID_BITS'(issue_ptr);
    issue_entry.valid    = decoded_instr_i.ex.valid;
  end

  always_comb begin
    rd_clobber_o = '0;
    for (int i = 0; i < NR_ENTRIES; i++)
      if (in_flight[i]) rd_clobber_o[mem[i].rd] = 1'b1;
    rd_clobber_o[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_ptr  <= '0;
      commit_ptr <= '0;
      count      <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) mem[i] <= '0;
    end else if (flush_i) begin
      issue_ptr  <= '0;
      commit_ptr <= '0;
      count      <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) mem[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (wb_hit[i]) begin
          mem[i].result <= wb_data_i[wb_sel[i]];
          mem[i].valid  <= 1'b1;
          if (wb_ex_i[wb_sel[i]].valid) mem[i].ex <= wb_ex_i[wb_sel[i]];
        end
      end
      if (commit_fire) begin
        mem[commit_ptr].valid <= 1'b0;
        commit_ptr            <= commit_ptr + 1'b1;
      end
      if (issue_fire) begin
        mem[issue_ptr] <= issue_entry;
        issue_ptr      <= issue_ptr + 1'b1;
      end
      count <= count + {{TW{1'b0}}, issue_fire} - {{TW{1'b0}}, commit_fire};
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// tb/tb_scoreboard.sv - directed self-checking bench for scoreboard
module tb_scoreboard;
  import scoreboard_pkg::*;

  localparam int NE = 4;
  localparam int NW = 4;
  localparam int TW = 2;

  logic                     clk = 1'b0;
  logic                     rst, flush, full, dvalid, dack, cvalid, cack;
  scoreboard_entry_t        dinstr, cinstr;
  logic [TW-1:0]            issued_id;
  logic [31:0]              clobber;
  logic [NW-1:0][TW-1:0]    wb_id;
  logic [NW-1:0][63:0]      wb_data;
  exception_t [NW-1:0]      wb_ex;
  logic [NW-1:0]            wb_valid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scoreboard #(.NR_ENTRIES(NE), .NR_WB(NW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .full_o(full),
    .decoded_instr_i(dinstr), .decoded_valid_i(dvalid), .decoded_ack_o(dack),
    .issued_trans_id_o(issued_id), .rd_clobber_o(clobber),
    .wb_trans_id_i(wb_id), .wb_data_i(wb_data), .wb_ex_i(wb_ex), .wb_valid_i(wb_valid),
    .commit_instr_o(cinstr), .commit_valid_o(cvalid), .commit_ack_i(cack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(input logic [4:0] rd, input logic exv);
    scoreboard_entry_t e;
    e          = '0;
    e.pc       = 64'h8000_0000 + {59'd0, rd} * 4;
    e.rd       = rd;
    e.rs1      = 5'd1;
    e.result   = {59'd0, rd};
    e.ex.valid = exv;
    e.ex.cause = exv ? ILLEGAL_INSTR : 64'd0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_wb();
    wb_valid = '0;
    wb_id    = '0;
    wb_data  = '0;
    wb_ex    = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dvalid = 1'b0; cack = 1'b0; dinstr = '0;
    clr_wb();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_full", full, 0);
    check("rst_ack", dack, 0);
    check("rst_cvalid", cvalid, 0);
    check("rst_clobber", clobber, 0);
    check("rst_id", issued_id, 0);

    // fill four entries, rd = 1..4
    for (int i = 0; i < 4; i++) begin
      dinstr = mk(5'(i + 1), 1'b0);
      dvalid = 1'b1;
      #1;
      check("fill_ack", dack, 1);
      check("fill_id", issued_id, 64'(i));
      step();
    end
    dinstr = mk(5'd5, 1'b0);
    #1;
    check("fill_full", full, 1);
    check("fill_clobber", clobber, 64'h1E);
    check("fill_ack5", dack, 0);

    // out-of-order writeback: id 2 first, then id 0
    dvalid = 1'b0;
    wb_valid[0] = 1'b1; wb_id[0] = 2'd2; wb_data[0] = 64'h22;
    step();
    clr_wb();
    #1;
    check("ooo_cv_after_wb2", cvalid, 0);
    wb_valid[0] = 1'b1; wb_id[0] = 2'd0; wb_data[0] = 64'h100;
    #1;
    check("ooo_no_bypass", cvalid, 0);
    step();
    clr_wb();
    #1;
    check("ooo_cv_after_wb0", cvalid, 1);
    check("ooo_result0", cinstr.result, 64'h100);
    check("ooo_tid0", 64'(cinstr.trans_id), 0);

    // full plus commit in the same cycle: issue must wait one cycle
    cack = 1'b1; dvalid = 1'b1; dinstr = mk(5'd5, 1'b0);
    #1;
    check("fullc_ack", dack, 0);
    step();
    cack = 1'b0;
    #1;
    check("fullc_cv_wait1", cvalid, 0);
    check("fullc_full", full, 0);
    check("fullc_ack_next", dack, 1);
    check("fullc_id_wrap", issued_id, 0);
    check("fullc_clobber", clobber, 64'h1C);
    step();
    dvalid = 1'b0;
    #1;
    check("refill_full", full, 1);
    check("refill_clobber", clobber, 64'h3C);

    // dual writeback to id 1: port 0 beats port 2
    wb_valid[0] = 1'b1; wb_id[0] = 2'd1; wb_data[0] = 64'hAA;
    wb_valid[2] = 1'b1; wb_id[2] = 2'd1; wb_data[2] = 64'hBB;
    step();
    clr_wb();
    #1;
    check("dual_cv", cvalid, 1);
    check("dual_result", cinstr.result, 64'hAA);
    check("dual_tid", 64'(cinstr.trans_id), 1);
    cack = 1'b1;
    step();
    #1;
    check("commit_id2_cv", cvalid, 1);
    check("commit_id2_result", cinstr.result, 64'h22);
    step();
    cack = 1'b0;
    #1;
    check("commit_id3_wait", cvalid, 0);
    check("commit_clobber", clobber, 64'h30);

    // flush with three in flight and a simultaneous issue
    dvalid = 1'b1; dinstr = mk(5'd6, 1'b0);
    step();
    flush = 1'b1; dinstr = mk(5'd9, 1'b0);
    #1;
    check("flush_ack", dack, 0);
    step();
    flush = 1'b0; dvalid = 1'b0;
    #1;
    check("flush_full", full, 0);
    check("flush_clobber", clobber, 0);
    check("flush_cv", cvalid, 0);
    check("flush_id", issued_id, 0);

    // decode exception commits with no writeback
    dvalid = 1'b1; dinstr = mk(5'd7, 1'b1);
    #1;
    check("exc_ack", dack, 1);
    check("exc_id", issued_id, 0);
    step();
    dvalid = 1'b0;
    #1;
    check("exc_cv", cvalid, 1);
    check("exc_cause", cinstr.ex.cause, 64'd2);
    check("exc_clobber", clobber, 64'h80);
    cack = 1'b1;
    step();
    cack = 1'b0;
    #1;
    check("exc_cv_after", cvalid, 0);
    check("exc_clobber_after", clobber, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
